// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format/opcode constants and immediate builder shared by the immediate stage
package imm_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [2:0] FMT_R = 3'b000;
    localparam logic [2:0] FMT_I = 3'b001;
    localparam logic [2:0] FMT_S = 3'b010;
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_J = 3'b101;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;

    // Built at the widest datapath; narrower stages keep the low bits, which is
    // identical to sign-extending at their own width.
    function automatic logic [MAX_XLEN-1:0] build_imm(input logic [31:0] inst,
                                                      input logic [2:0]  sel);
        logic unused_opcode;
        unused_opcode = ^inst[6:0];
        case (sel)
            FMT_I:   build_imm = {{52{inst[31]}}, inst[31:20]};
            FMT_S:   build_imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   build_imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   build_imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J:   build_imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: build_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered in_ready
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = !skid_valid;

    // The skid entry only fills while the output is stalled, so it is always
    // drained before a new word may enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_valid) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid && !skid_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator stage; IMM_GEN_ZIMM_EN adds CSR zimm
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      immSel,
    input  logic            auto_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [2:0]      out_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int PW = XLEN + 36;

    logic [2:0]          sel;
    logic                ill;
    logic [MAX_XLEN-1:0] imm_full;
    logic [XLEN-1:0]     imm_d;
    logic [PW-1:0]       d;
    logic [PW-1:0]       q;
    logic                unused_imm;

    always_comb begin
        sel = FMT_R;
        ill = 1'b0;
        if (auto_sel) begin
            case (inst[6:0])
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: sel = FMT_I;
                OP_STORE:          sel = FMT_S;
                OP_BRANCH:         sel = FMT_B;
                OP_LUI, OP_AUIPC:  sel = FMT_U;
                OP_JAL:            sel = FMT_J;
                OP_REG:            sel = FMT_R;
                OP_IMM_32: begin
                    if (XLEN == 64) sel = FMT_I;
                    else            ill = 1'b1;
                end
                OP_REG_32: begin
                    if (XLEN != 64) ill = 1'b1;
                end
                default:           ill = 1'b1;
            endcase
        end else begin
            sel = (immSel > FMT_J) ? FMT_R : immSel;
        end
    end

    assign imm_full   = build_imm(inst, sel);
    assign unused_imm = ^imm_full;

    always_comb begin
        imm_d = imm_full[XLEN-1:0];
`ifdef IMM_GEN_ZIMM_EN
        // CSR immediate forms carry an unsigned 5-bit zimm in the rs1 field.
        if (auto_sel && inst[6:0] == OP_SYSTEM && inst[14])
            imm_d = {{(XLEN-5){1'b0}}, inst[19:15]};
`endif
    end

    assign d = {ill, sel, inst, imm_d};
    assign {illegal, out_sel, out_inst, imm} = q;

    generate
        if (SKID != 0) begin : g_skid
            imm_skid_buf #(.W(PW)) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (d),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (q)
            );
        end else begin : g_reg
            assign in_ready = !out_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    q         <= '0;
                end else if (in_valid && in_ready) begin
                    out_valid <= 1'b1;
                    q         <= d;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench: XLEN=32/SKID=1 and XLEN=64/SKID=0 side by side
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  isel;
        logic        asel;
    } stim_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] inst_i   [2];
    logic [2:0]  isel_i   [2];
    logic        asel_i   [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [31:0] out_inst [2];
    logic [2:0]  out_sel  [2];
    logic [63:0] imm_w    [2];
    logic        illegal  [2];

    stim_t stim_q[2][$];
    exp_t  exp_q [2][$];
    int    acc_cnt[2];
    int    del_cnt[2];
    int    total = 0;
    int    bad = 0;
    logic  stall = 1'b0;
    logic  burst = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(int g, string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %h expected %h", g, name, act, exp);
        end
    endtask

    // Reference: immediates as signed integer values scaled by their implicit zero bits.
    function automatic exp_t model(stim_t s, int xlen);
        exp_t        e;
        longint      v;
        logic [63:0] u;
        logic [2:0]  f;
        e.inst = s.inst;
        e.ill  = 1'b0;
        f      = 3'd0;
        if (s.asel) begin
            case (s.inst[6:0])
                7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 3'd1;
                7'h23: f = 3'd2;
                7'h63: f = 3'd3;
                7'h37, 7'h17: f = 3'd4;
                7'h6F: f = 3'd5;
                7'h33: f = 3'd0;
                7'h1B: if (xlen == 64) f = 3'd1; else e.ill = 1'b1;
                7'h3B: if (xlen != 64) e.ill = 1'b1;
                default: e.ill = 1'b1;
            endcase
        end else begin
            f = (s.isel > 3'd5) ? 3'd0 : s.isel;
        end
        case (f)
            3'd1: v = longint'($signed(s.inst[31:20]));
            3'd2: v = longint'($signed({s.inst[31:25], s.inst[11:7]}));
            3'd3: v = longint'($signed({s.inst[31], s.inst[7], s.inst[30:25], s.inst[11:8]})) * 2;
            3'd4: v = longint'($signed(s.inst[31:12])) * 4096;
            3'd5: v = longint'($signed({s.inst[31], s.inst[19:12], s.inst[20], s.inst[30:21]})) * 2;
            default: v = 0;
        endcase
`ifdef IMM_GEN_ZIMM_EN
        if (s.asel && s.inst[6:0] == 7'h73 && s.inst[14]) begin
            f = 3'd1;
            v = longint'(s.inst[19:15]);
        end
`endif
        u     = v;
        e.sel = f;
        e.imm = (xlen == 32) ? {32'h0, u[31:0]} : u;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int XL = (g == 0) ? 32 : 64;
        localparam int SK = (g == 0) ? 1 : 0;
        logic [XL-1:0] imm_l;

        imm_gen_stage #(.XLEN(XL), .SKID(SK)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .inst      (inst_i[g]),
            .immSel    (isel_i[g]),
            .auto_sel  (asel_i[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_inst  (out_inst[g]),
            .out_sel   (out_sel[g]),
            .imm       (imm_l),
            .illegal   (illegal[g])
        );

        assign imm_w[g] = 64'(imm_l);

        initial begin : drv
            logic  fire;
            stim_t cur;
            in_valid[g] = 1'b0;
            inst_i[g]   = '0;
            isel_i[g]   = '0;
            asel_i[g]   = 1'b0;
            out_ready[g] = 1'b0;
            acc_cnt[g]  = 0;
            forever begin
                @(negedge clk);
                fire = in_valid[g] && in_ready[g];
                @(posedge clk);
                #1;
                out_ready[g] = stall ? 1'b0 : ($urandom_range(3) != 0);
                if (!rst_n) begin
                    in_valid[g] = 1'b0;
                    exp_q[g].delete();
                end else begin
                    if (fire) begin
                        exp_q[g].push_back(model(cur, XL));
                        acc_cnt[g]++;
                        in_valid[g] = 1'b0;
                    end
                    if (!in_valid[g] && stim_q[g].size() > 0 && (burst || $urandom_range(3) != 0)) begin
                        cur         = stim_q[g].pop_front();
                        inst_i[g]   = cur.inst;
                        isel_i[g]   = cur.isel;
                        asel_i[g]   = cur.asel;
                        in_valid[g] = 1'b1;
                    end
                end
            end
        end

        initial begin : mon
            logic        hv;
            logic [31:0] hi;
            logic [2:0]  hs;
            logic [63:0] hm;
            logic        hl;
            exp_t        e;
            hv = 1'b0;
            del_cnt[g] = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hv = 1'b0;
                    chk(g, "rst_out_valid", 64'(out_valid[g]), 64'd0);
                    chk(g, "rst_imm", imm_w[g], 64'd0);
                    chk(g, "rst_sel", 64'(out_sel[g]), 64'd0);
                end else if (out_valid[g]) begin
                    if (hv) begin
                        chk(g, "hold_inst", 64'(out_inst[g]), 64'(hi));
                        chk(g, "hold_sel", 64'(out_sel[g]), 64'(hs));
                        chk(g, "hold_imm", imm_w[g], hm);
                        chk(g, "hold_ill", 64'(illegal[g]), 64'(hl));
                    end
                    if (out_ready[g]) begin
                        hv = 1'b0;
                        if (exp_q[g].size() == 0) begin
                            chk(g, "spurious_out_valid", 64'(out_valid[g]), 64'd0);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk(g, "inst", 64'(out_inst[g]), 64'(e.inst));
                            chk(g, "sel", 64'(out_sel[g]), 64'(e.sel));
                            chk(g, "imm", imm_w[g], e.imm);
                            chk(g, "illegal", 64'(illegal[g]), 64'(e.ill));
                            del_cnt[g]++;
                        end
                    end else begin
                        hv = 1'b1;
                        hi = out_inst[g];
                        hs = out_sel[g];
                        hm = imm_w[g];
                        hl = illegal[g];
                    end
                end else begin
                    if (hv) chk(g, "hold_valid", 64'(out_valid[g]), 64'd1);
                    hv = 1'b0;
                end
            end
        end
    end

    task automatic push_both(logic [31:0] inst, logic [2:0] isel, logic asel);
        stim_t s;
        s.inst = inst;
        s.isel = isel;
        s.asel = asel;
        stim_q[0].push_back(s);
        stim_q[1].push_back(s);
    endtask

    task automatic push_random(int n);
        logic [6:0] ops [15];
        logic [31:0] w;
        int k;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h00};
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            k = $urandom_range(15);
            if (k < 15) w[6:0] = ops[k];
            push_both(w, 3'($urandom_range(7)), $urandom_range(3) != 0);
        end
    endtask

    task automatic wait_drain(string name, int max);
        int n = 0;
        while ((stim_q[0].size() != 0 || stim_q[1].size() != 0 || in_valid[0] || in_valid[1] ||
                exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after %0d cycles", name, n);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk(g, "post_rst_in_ready", 64'(in_ready[g]), 64'd1);
            chk(g, "post_rst_out_valid", 64'(out_valid[g]), 64'd0);
        end
    endtask

    initial begin
        int d0;
        int d1;
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        pulse_reset();

        push_both(32'hFFF00093, 3'd0, 1'b1);
        push_both(32'h800000B7, 3'd0, 1'b1);
        push_both(32'hFE000EE3, 3'd0, 1'b1);
        push_both(32'h0000007F, 3'd0, 1'b1);
        push_both(32'hFFFFFFFF, 3'd7, 1'b0);
        push_both(32'hFFFFFFFF, 3'd6, 1'b0);
        push_both(32'h000FE073, 3'd0, 1'b1);
        push_both(32'h0000101B, 3'd0, 1'b1);
        wait_drain("directed", 200);

        push_random(300);
        wait_drain("random", 6000);

        stall = 1'b1;
        @(posedge clk);
        #2;
        acc_cnt[0] = 0;
        d0 = del_cnt[0];
        d1 = del_cnt[1];
        burst = 1'b1;
        push_random(4);
        n = 0;
        while (acc_cnt[0] < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(0, "bp_in_ready_after_2", 64'(in_ready[0]), 64'd0);
        repeat (3) @(negedge clk);
        chk(0, "bp_accepts_while_full", 64'(acc_cnt[0]), 64'd2);
        stall = 1'b0;
        wait_drain("backpressure", 200);
        chk(0, "bp_delivered", 64'(del_cnt[0] - d0), 64'd4);
        chk(1, "bp_delivered", 64'(del_cnt[1] - d1), 64'd4);

        burst = 1'b0;
        push_random(30);
        repeat (8) @(posedge clk);
        pulse_reset();
        wait_drain("post_reset", 1000);

        for (int g = 0; g < 2; g++)
            chk(g, "scoreboard_empty", 64'(exp_q[g].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Accepts a 32-bit RISC-V instruction stream over a valid/ready handshake.
- Produces the sign-extended XLEN-bit immediate plus the decoded format, one cycle later.
- Selector is either external (legacy immSel) or derived from the opcode; an optional skid buffer sustains full throughput under back-pressure. Sits between fetch and the register-read/execute stage.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register, in_ready = !out_valid | out_ready.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept
- inst  input  32  instruction word
- immSel  input  3  external format: R=000 I=001 S=010 B=011 U=100 J=101
- auto_sel  input  1  1 = derive format from inst[6:0] and ignore immSel
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- out_inst  output  32  instruction passed through
- out_sel  output  3  format actually used
- imm  output  XLEN  immediate
- illegal  output  1  auto_sel opcode not recognised

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_inst=0, out_sel=000, imm=0, illegal=0, skid entry empty. in_ready=1 as soon as rst_n is high.
- A reset asserted mid-transfer discards all held data; no partial output.
- Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready. Latency is exactly 1 cycle from accept to out_valid.
- While out_valid&!out_ready, out_inst, out_sel, imm and illegal hold stable.
- SKID=1:
  - Primary output register plus one skid entry.
  - in_ready = !skid_valid, taken from a flop only.
  - An accept while output is stalled writes the skid entry.
  - On the next output transfer the skid entry moves to the output register; a simultaneous accept is legal only when the skid entry is empty.
  - Order is preserved.
  - Throughput is 1/cycle when out_ready stays high.
- SKID=0:
  - Simultaneous output transfer and input accept in one cycle replaces the output register, giving no bubble.
- Auto decode (auto_sel=1), by inst[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011
  - XLEN=64 only: 0011011 -> I, 0111011 -> R
  - Anything else -> R with illegal=1.
- With auto_sel=0, illegal=0. immSel values 110/111 give R.
- Immediate formats; the field layout is unchanged from the previous generation, with the sign bit inst[31] replicated to XLEN:
  - I = inst[31:20]
  - S = inst[31:25],inst[11:7]
  - B = inst[31],inst[7],inst[30:25],inst[11:8],0
  - U = inst[31:12],12'b0, with bits XLEN-1:32 sign-filled when XLEN=64
  - J = inst[31],inst[19:12],inst[20],inst[30:21],0
  - R = 0
- Format selection happens before the register; no combinational path from inst to imm.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: for auto-decoded opcode 1110011 with inst[14]=1 (CSRRWI/CSRRSI/CSRRCI), imm = zero-extended inst[19:15], out_sel = I.
- Not defined: such instructions get the plain sign-extended I immediate.

Decomposition:
- Shared package imm_pkg holds:
  - the 3-bit format constants R, I, S, B, U, J;
  - the opcode constants;
  - a combinational function build_imm(inst, sel) returning XLEN bits.
- One natural sub-module, imm_skid_buf: a generic 2-entry valid/ready skid buffer, payload width parametrised. It is instantiated when SKID=1.

Test Plan:
- Reset then idle: rst_n low mid-stream -> out_valid=0, imm=0, in_ready=1 after release; no stale output.
- auto_sel=1, XLEN=32, inst=0xFFF00093 (addi x1,x0,-1) -> next cycle out_sel=001, imm=0xFFFFFFFF, illegal=0.
- auto_sel=1, XLEN=64:
  - inst=0x800000B7 (lui) -> imm=0xFFFFFFFF80000000;
  - inst=0xFE000EE3 (beq, offset -4) -> out_sel=011, imm=0xFFFFFFFFFFFFFFFC.
- Back-pressure, SKID=1:
  - 4 back-to-back instructions with out_ready low for 3 cycles -> in_ready falls after the second accept;
  - outputs hold;
  - all 4 delivered in order;
  - no loss or duplication.
- auto_sel=1, inst=0x0000007F -> out_sel=000, imm=0, illegal=1. auto_sel=0, immSel=111 -> imm=0, illegal=0.
- IMM_GEN_ZIMM_EN defined, inst=0x000FE073 (csrrsi x0,0,31) -> imm=0x0000001F. Undefined -> imm=0x00000000.
